// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared types and constants for the multicycle control unit:
//            state encodings, ALU/PC mux encodings, default opcode values
//            and the packed control-word structure.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // alu_src_b select
  localparam logic [1:0] c_srcb_reg    = 2'b00;
  localparam logic [1:0] c_srcb_one    = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;

  // alu_op select
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  // pc_source select
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // Default opcode values
  localparam int unsigned c_op_rtype = 31;
  localparam int unsigned c_op_lw    = 32;
  localparam int unsigned c_op_sw    = 33;
  localparam int unsigned c_op_j     = 34;
  localparam int unsigned c_op_beq   = 35;
  localparam int unsigned c_op_bne   = 36;
  localparam int unsigned c_op_addi  = 37;

  // Datapath control word, decoded from the current state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch_ne;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_opcode_classify.sv
`default_nettype none
// ============================================================================
// Module   : opcode_classify
// Purpose  : Combinational opcode decoder producing one-hot class flags.
//            Exactly one output is high for any opcode (opcode values must
//            be distinct).
// Ports    : opcode     in  OPCODE_W  opcode field from the IR
//            is_rtype .. is_addi  out 1  instruction class flags
//            is_illegal out 1  opcode matches no known class
// Revision : 1.0 - initial release
// ============================================================================
module opcode_classify
  import multicycle_control_pkg::*;
#(
  parameter int unsigned          OPCODE_W = 8,
  parameter logic [OPCODE_W-1:0]  OP_RTYPE = OPCODE_W'(c_op_rtype),
  parameter logic [OPCODE_W-1:0]  OP_LW    = OPCODE_W'(c_op_lw),
  parameter logic [OPCODE_W-1:0]  OP_SW    = OPCODE_W'(c_op_sw),
  parameter logic [OPCODE_W-1:0]  OP_J     = OPCODE_W'(c_op_j),
  parameter logic [OPCODE_W-1:0]  OP_BEQ   = OPCODE_W'(c_op_beq),
  parameter logic [OPCODE_W-1:0]  OP_BNE   = OPCODE_W'(c_op_bne),
  parameter logic [OPCODE_W-1:0]  OP_ADDI  = OPCODE_W'(c_op_addi)
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_rtype,
  output logic                is_lw,
  output logic                is_sw,
  output logic                is_j,
  output logic                is_beq,
  output logic                is_bne,
  output logic                is_addi,
  output logic                is_illegal
);

  always_comb begin
    is_rtype   = (opcode == OP_RTYPE);
    is_lw      = (opcode == OP_LW);
    is_sw      = (opcode == OP_SW);
    is_j       = (opcode == OP_J);
    is_beq     = (opcode == OP_BEQ);
    is_bne     = (opcode == OP_BNE);
    is_addi    = (opcode == OP_ADDI);
    is_illegal = ~(is_rtype | is_lw | is_sw | is_j | is_beq | is_bne | is_addi);
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore control FSM for the multicycle 8-bit-opcode datapath.
//            Steps each instruction through fetch/decode/execute/memory/
//            write-back, stalls on mem_ready, flags illegal opcodes.
// Macro    : MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN - illegal opcodes enter a
//            TRAP state (left only by reset) and set sticky illegal_op.
//            Undefined: illegal opcodes act as a 2-cycle NOP.
// Ports    : clk, rst_n (async, active-low)
//            opcode [OPCODE_W], mem_ready            - inputs
//            pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
//            reg_dst, reg_write, mem_to_reg, branch_ne, alu_src_a,
//            alu_src_b[2], alu_op[2], pc_source[2]  - datapath controls
//            instr_done, illegal_op, state[4]        - status / debug
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned          OPCODE_W = 8,
  parameter logic [OPCODE_W-1:0]  OP_RTYPE = OPCODE_W'(c_op_rtype),
  parameter logic [OPCODE_W-1:0]  OP_LW    = OPCODE_W'(c_op_lw),
  parameter logic [OPCODE_W-1:0]  OP_SW    = OPCODE_W'(c_op_sw),
  parameter logic [OPCODE_W-1:0]  OP_J     = OPCODE_W'(c_op_j),
  parameter logic [OPCODE_W-1:0]  OP_BEQ   = OPCODE_W'(c_op_beq),
  parameter logic [OPCODE_W-1:0]  OP_BNE   = OPCODE_W'(c_op_bne),
  parameter logic [OPCODE_W-1:0]  OP_ADDI  = OPCODE_W'(c_op_addi)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                branch_ne,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state
);

  state_t r_state;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  logic w_is_rtype, w_is_lw, w_is_sw, w_is_j;
  logic w_is_beq, w_is_bne, w_is_addi, w_is_illegal;

  opcode_classify #(
    .OPCODE_W (OPCODE_W),
    .OP_RTYPE (OP_RTYPE),
    .OP_LW    (OP_LW),
    .OP_SW    (OP_SW),
    .OP_J     (OP_J),
    .OP_BEQ   (OP_BEQ),
    .OP_BNE   (OP_BNE),
    .OP_ADDI  (OP_ADDI)
  ) u_classify (
    .opcode     (opcode),
    .is_rtype   (w_is_rtype),
    .is_lw      (w_is_lw),
    .is_sw      (w_is_sw),
    .is_j       (w_is_j),
    .is_beq     (w_is_beq),
    .is_bne     (w_is_bne),
    .is_addi    (w_is_addi),
    .is_illegal (w_is_illegal)
  );

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  logic r_illegal_op;
`endif

  // State register; opcode is only consulted in DECODE and MEM_ADDR here
  // (BRANCH uses it only for the branch_ne output).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
      r_illegal_op <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_lw || w_is_sw)         r_state <= S_MEM_ADDR;
          else if (w_is_rtype)            r_state <= S_R_EXEC;
          else if (w_is_beq || w_is_bne)  r_state <= S_BRANCH;
          else if (w_is_j)                r_state <= S_JUMP;
          else if (w_is_addi)             r_state <= S_ADDI_EXEC;
          else begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            r_state      <= S_TRAP;
            r_illegal_op <= 1'b1;
`else
            r_state      <= S_FETCH;
`endif
          end
        end
        S_MEM_ADDR:  r_state <= w_is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:    if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR:    if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:    r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                     r_state <= S_FETCH;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        S_TRAP:      r_state <= S_TRAP;  // exit only through reset
`endif
        default:     r_state <= S_FETCH; // unused codes recover
      endcase
    end
  end

  // Moore decode; only FETCH/MEM_WR strobes qualify with mem_ready.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = c_srcb_one;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = c_srcb_imm;
`ifndef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        w_ctrl.instr_done = w_is_illegal;  // illegal opcode retires as NOP
`endif
      end
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = c_srcb_imm;
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.i_or_d     = 1'b1;
        w_ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = c_aluop_funct;
      end
      S_R_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = c_aluop_sub;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = c_pcsrc_aluout;
        w_ctrl.branch_ne     = w_is_bne;
        w_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.pc_source  = c_pcsrc_jump;
        w_ctrl.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = c_srcb_imm;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      default: w_ctrl = '0;  // TRAP and unused codes drive nothing
    endcase
  end

  // Outputs are forced low for as long as reset is asserted, not just
  // from the next edge.
  assign w_ctrl_out = rst_n ? w_ctrl : '0;

  assign pc_write      = w_ctrl_out.pc_write;
  assign pc_write_cond = w_ctrl_out.pc_write_cond;
  assign ir_write      = w_ctrl_out.ir_write;
  assign i_or_d        = w_ctrl_out.i_or_d;
  assign mem_read      = w_ctrl_out.mem_read;
  assign mem_write     = w_ctrl_out.mem_write;
  assign reg_dst       = w_ctrl_out.reg_dst;
  assign reg_write     = w_ctrl_out.reg_write;
  assign mem_to_reg    = w_ctrl_out.mem_to_reg;
  assign branch_ne     = w_ctrl_out.branch_ne;
  assign alu_src_a     = w_ctrl_out.alu_src_a;
  assign alu_src_b     = w_ctrl_out.alu_src_b;
  assign alu_op        = w_ctrl_out.alu_op;
  assign pc_source     = w_ctrl_out.pc_source;
  assign instr_done    = w_ctrl_out.instr_done;
  assign state         = r_state;

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  assign illegal_op = r_illegal_op & rst_n;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. The stimulus task
//            drives one cycle of inputs and queues the hand-derived state
//            and control word for that cycle; a monitor pops and compares
//            on the falling edge. Honours MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch_ne;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       ctl;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] opcode = 8'd0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_dst, reg_write, mem_to_reg, branch_ne, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .branch_ne     (branch_ne),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  // Expected control words, one per state/condition, taken from the
  // state-by-state output list.
  ctl_t e_z, e_fw, e_fr, e_dec, e_dnop, e_ma, e_mr, e_mwb, e_mww, e_mwr;
  ctl_t e_rx, e_rw, e_beq, e_bne, e_jmp, e_ax, e_aw, e_trp;

  // Monitor: compares the DUT against the queued expectation every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ctl_t a;
      e = sb.pop_front();
      a = '{pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
            reg_dst, reg_write, mem_to_reg, branch_ne, alu_src_a, alu_src_b,
            alu_op, pc_source, instr_done, illegal_op};
      n_checks++;
      if (state !== e.st || a !== e.ctl) begin
        n_fail++;
        $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                 e.tag, state, a, e.st, e.ctl);
      end
    end
  end

  task automatic step(input logic rst, input logic rdy, input logic [7:0] op,
                      input logic [3:0] st, input ctl_t c, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    mem_ready = rdy;
    opcode    = op;
    e.st = st; e.ctl = c; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin
    e_z   = '0;
    e_fw  = e_z;  e_fw.mem_read = 1'b1; e_fw.alu_src_b = 2'b01;
    e_fr  = e_fw; e_fr.ir_write = 1'b1; e_fr.pc_write = 1'b1;
    e_dec = e_z;  e_dec.alu_src_b = 2'b10;
    e_dnop = e_dec; e_dnop.instr_done = 1'b1;
    e_ma  = e_z;  e_ma.alu_src_a = 1'b1; e_ma.alu_src_b = 2'b10;
    e_mr  = e_z;  e_mr.mem_read = 1'b1; e_mr.i_or_d = 1'b1;
    e_mwb = e_z;  e_mwb.reg_write = 1'b1; e_mwb.mem_to_reg = 1'b1; e_mwb.instr_done = 1'b1;
    e_mww = e_z;  e_mww.mem_write = 1'b1; e_mww.i_or_d = 1'b1;
    e_mwr = e_mww; e_mwr.instr_done = 1'b1;
    e_rx  = e_z;  e_rx.alu_src_a = 1'b1; e_rx.alu_op = 2'b10;
    e_rw  = e_z;  e_rw.reg_write = 1'b1; e_rw.reg_dst = 1'b1; e_rw.instr_done = 1'b1;
    e_beq = e_z;  e_beq.alu_src_a = 1'b1; e_beq.alu_op = 2'b01; e_beq.pc_write_cond = 1'b1;
                  e_beq.pc_source = 2'b01; e_beq.instr_done = 1'b1;
    e_bne = e_beq; e_bne.branch_ne = 1'b1;
    e_jmp = e_z;  e_jmp.pc_write = 1'b1; e_jmp.pc_source = 2'b10; e_jmp.instr_done = 1'b1;
    e_ax  = e_ma;
    e_aw  = e_z;  e_aw.reg_write = 1'b1; e_aw.instr_done = 1'b1;
    e_trp = e_z;  e_trp.illegal_op = 1'b1;

    // Power-on reset, strobes masked even with mem_ready high
    step(0, 1, 8'd32, 4'd0, e_z,  "por_masked");
    // lw into MEM_RD, then asynchronous reset in the middle of the stall
    step(1, 1, 8'd32, 4'd0, e_fr, "pre_fetch");
    step(1, 1, 8'd32, 4'd1, e_dec,"pre_decode");
    step(1, 1, 8'd32, 4'd2, e_ma, "pre_memaddr");
    step(1, 0, 8'd32, 4'd3, e_mr, "pre_memrd");
    step(0, 1, 8'd32, 4'd0, e_z,  "async_reset");
    step(0, 1, 8'd31, 4'd0, e_z,  "reset_hold");
    // R-type after release: 0,1,6,7,0
    step(1, 1, 8'd31, 4'd0, e_fr, "r_fetch");
    step(1, 0, 8'd31, 4'd1, e_dec,"r_decode");
    step(1, 0, 8'd32, 4'd6, e_rx, "r_exec_opchg");
    step(1, 0, 8'd32, 4'd7, e_rw, "r_wb");
    // lw with 2 wait states in MEM_RD: CPI 7
    step(1, 1, 8'd32, 4'd0, e_fr, "lw_fetch");
    step(1, 0, 8'd32, 4'd1, e_dec,"lw_decode");
    step(1, 0, 8'd32, 4'd2, e_ma, "lw_memaddr");
    step(1, 0, 8'd32, 4'd3, e_mr, "lw_memrd_w1");
    step(1, 0, 8'd32, 4'd3, e_mr, "lw_memrd_w2");
    step(1, 1, 8'd32, 4'd3, e_mr, "lw_memrd_rdy");
    step(1, 0, 8'd32, 4'd4, e_mwb,"lw_memwb");
    // FETCH stall of 3 cycles (opcode changes ignored), then sw zero-wait
    step(1, 0, 8'd34, 4'd0, e_fw, "stall_1");
    step(1, 0, 8'd35, 4'd0, e_fw, "stall_2");
    step(1, 0, 8'd36, 4'd0, e_fw, "stall_3");
    step(1, 1, 8'd33, 4'd0, e_fr, "stall_ready");
    step(1, 0, 8'd33, 4'd1, e_dec,"sw_decode");
    step(1, 0, 8'd33, 4'd2, e_ma, "sw_memaddr");
    step(1, 1, 8'd33, 4'd5, e_mwr,"sw_memwr");
    // sw with one wait state
    step(1, 1, 8'd33, 4'd0, e_fr, "sw2_fetch");
    step(1, 1, 8'd33, 4'd1, e_dec,"sw2_decode");
    step(1, 1, 8'd33, 4'd2, e_ma, "sw2_memaddr");
    step(1, 0, 8'd33, 4'd5, e_mww,"sw2_memwr_wait");
    step(1, 1, 8'd33, 4'd5, e_mwr,"sw2_memwr_rdy");
    // beq and bne
    step(1, 1, 8'd35, 4'd0, e_fr, "beq_fetch");
    step(1, 0, 8'd35, 4'd1, e_dec,"beq_decode");
    step(1, 0, 8'd35, 4'd8, e_beq,"beq_branch");
    step(1, 1, 8'd36, 4'd0, e_fr, "bne_fetch");
    step(1, 0, 8'd36, 4'd1, e_dec,"bne_decode");
    step(1, 0, 8'd36, 4'd8, e_bne,"bne_branch");
    // jump and addi
    step(1, 1, 8'd34, 4'd0, e_fr, "j_fetch");
    step(1, 0, 8'd34, 4'd1, e_dec,"j_decode");
    step(1, 0, 8'd34, 4'd9, e_jmp,"j_jump");
    step(1, 1, 8'd37, 4'd0, e_fr, "addi_fetch");
    step(1, 0, 8'd37, 4'd1, e_dec,"addi_decode");
    step(1, 0, 8'd37, 4'd10,e_ax, "addi_exec");
    step(1, 0, 8'd37, 4'd11,e_aw, "addi_wb");
    // Illegal opcode 0xFF
    step(1, 1, 8'hFF, 4'd0, e_fr, "ill_fetch");
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    step(1, 1, 8'hFF, 4'd1, e_dec,"ill_decode");
    for (int i = 0; i < 20; i++)
      step(1, logic'(i % 2), 8'd31, 4'd12, e_trp, "ill_trap");
    step(0, 1, 8'd31, 4'd0, e_z,  "trap_reset");
    step(1, 1, 8'd31, 4'd0, e_fr, "post_trap_fetch");
    step(1, 1, 8'd31, 4'd1, e_dec,"post_trap_decode");
`else
    step(1, 1, 8'hFF, 4'd1, e_dnop,"ill_nop_decode");
    step(1, 1, 8'd31, 4'd0, e_fr, "post_nop_fetch");
    step(1, 1, 8'd31, 4'd1, e_dec,"post_nop_decode");
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
